// File: rtl/shift_left8_seq_if.sv
// Handshake and data bundle for the sequential 8-bit shift/rotate unit.
// The requester drives start/op/d_in/shamt and observes d_out/busy/done.
interface shift_left8_seq_if;
    logic       start;
    logic       op;
    logic [7:0] d_in;
    logic [2:0] shamt;
    logic [7:0] d_out;
    logic       busy;
    logic       done;

    modport master (
        output start, op, d_in, shamt,
        input  d_out, busy, done
    );

    modport slave (
        input  start, op, d_in, shamt,
        output d_out, busy, done
    );
endinterface

// File: rtl/shift_left8_seq.sv
// Sequential 8-bit left shifter / rotator: one bit position per clock.
// An operation is accepted in IDLE, stepped in SHIFT until the counter
// reaches its last step, and signalled by a single-cycle DONE state.
module shift_left8_seq (
    input  logic            clk,
    input  logic            reset,
    shift_left8_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] work;
    logic [2:0] count;
    logic       op_q;
    logic [7:0] d_out_q;
    logic [7:0] step_val;

    // One step of the latched operation: zero fill or wrap of the MSB.
    assign step_val = {work[6:0], op_q & work[7]};

    // Outputs are pure decodes of the state register, so no input reaches them.
    assign bus.busy  = (state == SHIFT);
    assign bus.done  = (state == DONE);
    assign bus.d_out = d_out_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE and DONE always falls back to IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.shamt == 3'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count == 3'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture in IDLE, stepping in SHIFT, result published on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work    <= 8'h00;
            count   <= 3'd0;
            op_q    <= 1'b0;
            d_out_q <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        work  <= bus.d_in;
                        op_q  <= bus.op;
                        count <= bus.shamt;
                        if (bus.shamt == 3'd0) begin
                            d_out_q <= bus.d_in;
                        end
                    end
                end
                SHIFT: begin
                    work  <= step_val;
                    count <= count - 3'd1;
                    if (count == 3'd1) begin
                        d_out_q <= step_val;
                    end
                end
                DONE: begin
                    work <= work;
                end
                default: begin
                    work <= work;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_left8_seq.sv
// Directed testbench for shift_left8_seq: hand-computed vectors, timing of
// busy/done, input isolation during an operation, async reset abort and
// back-to-back operation with start held high.
module tb_shift_left8_seq;

    logic clk;
    logic reset;
    int   n_asserts;
    int   n_fail;

    shift_left8_seq_if bus ();

    shift_left8_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports tag/observed/expected on a miss.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and watch it for shamt+3 cycles after the start edge.
    task automatic apply_stimulus(input string tag, input logic o, input logic [7:0] d,
                                  input logic [2:0] sh, input logic [7:0] exp_dout,
                                  input bit scramble);
        logic [7:0] prev;
        int         busy_n;
        int         done_n;
        int         first_done;
        bit         early;
        @(negedge clk);
        prev      = bus.d_out;
        bus.start = 1'b1;
        bus.op    = o;
        bus.d_in  = d;
        bus.shamt = sh;
        @(posedge clk);
        busy_n     = 0;
        done_n     = 0;
        first_done = -1;
        early      = 1'b0;
        for (int c = 1; c <= int'(sh) + 3; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) begin
                done_n++;
                if (first_done < 0) first_done = c;
            end
            if (first_done < 0 && bus.d_out !== prev) early = 1'b1;
            if (scramble && bus.busy === 1'b1) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.d_in  = 8'($urandom);
                bus.op    = ~bus.op;
                bus.shamt = 3'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        check_output({tag, "_busy_cycles"}, 32'(busy_n), 32'(sh));
        check_output({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        check_output({tag, "_done_cycle"}, 32'(first_done), 32'(int'(sh) + 1));
        check_output({tag, "_dout_early"}, 32'(early), 32'd0);
        check_output({tag, "_dout"}, 32'(bus.d_out), 32'(exp_dout));
    endtask

    // Directed sequence.
    initial begin
        logic [7:0] exp_busy;
        logic [7:0] exp_done;
        int         done_n;

        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.d_in  = 8'h00;
        bus.shamt = 3'd0;
        #1;
        check_output("reset_dout", 32'(bus.d_out), 32'h00);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("idle_hold_busy", 32'(bus.busy), 32'd0);
        check_output("idle_hold_done", 32'(bus.done), 32'd0);

        apply_stimulus("shl3",  1'b0, 8'hB5, 3'd3, 8'hA8, 1'b0);
        apply_stimulus("rotl3", 1'b1, 8'hB5, 3'd3, 8'hAD, 1'b0);
        apply_stimulus("shl0",  1'b0, 8'h5A, 3'd0, 8'h5A, 1'b0);
        apply_stimulus("shl7_scramble", 1'b0, 8'hFF, 3'd7, 8'h80, 1'b1);

        // Abort a long rotate with reset during its 4th SHIFT cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.d_in  = 8'h81;
        bus.shamt = 3'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("abort_busy_before", 32'(bus.busy), 32'd1);
        #2;
        reset     = 1'b1;
        bus.start = 1'b1;
        #1;
        check_output("abort_async_dout", 32'(bus.d_out), 32'h00);
        check_output("abort_async_busy", 32'(bus.busy), 32'd0);
        check_output("abort_async_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check_output("start_in_reset_busy", 32'(bus.busy), 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        done_n    = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_n++;
        end
        check_output("abort_no_done", 32'(done_n), 32'd0);
        check_output("abort_dout_held", 32'(bus.d_out), 32'h00);
        apply_stimulus("rotl1_after_reset", 1'b1, 8'h81, 3'd1, 8'h03, 1'b0);

        // Back-to-back with start held high: 3C<<2 = F0, then rotl1(96) = 2D.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.d_in  = 8'h3C;
        bus.shamt = 3'd2;
        @(posedge clk);
        @(negedge clk);
        bus.op    = 1'b1;
        bus.d_in  = 8'h96;
        bus.shamt = 3'd1;
        exp_busy  = 8'b0001_0011;
        exp_done  = 8'b0010_0100;
        done_n    = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            check_output($sformatf("b2b_busy_c%0d", c), 32'(bus.busy), 32'(exp_busy[c-1]));
            check_output($sformatf("b2b_done_c%0d", c), 32'(bus.done), 32'(exp_done[c-1]));
            if (bus.done === 1'b1) done_n++;
            if (c == 3) check_output("b2b_first_dout", 32'(bus.d_out), 32'hF0);
            if (c == 6) begin
                check_output("b2b_second_dout", 32'(bus.d_out), 32'h2D);
                bus.start = 1'b0;
            end
        end
        check_output("b2b_done_pulses", 32'(done_n), 32'd2);
        check_output("b2b_dout_hold", 32'(bus.d_out), 32'h2D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_left8_seq.md
SHIFT_LEFT8_SEQ -- requirements
Module: shift_left8_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port list (name  direction  width  meaning) SHALL be:
  clk      input   1  rising-edge clock
  reset    input   1  asynchronous, active-high reset
  start    input   1  request; sampled only in IDLE
  op       input   1  0 = logical shift left (zero fill), 1 = rotate left
  d_in     input   8  operand
  shamt    input   3  shift amount, 0..7
  d_out    output  8  last completed result, registered
  busy     output  1  high while an operation is in progress (SHIFT state)
  done     output  1  one-cycle completion pulse (DONE state)
REQ-003 No parameters; widths SHALL be fixed as listed.

Function
REQ-004 FSM states SHALL be IDLE, SHIFT and DONE; encoding is free.
REQ-005 In IDLE with start=1 at edge E0, the block SHALL latch d_in into a working register, latch op, and load shamt into a 3-bit down-counter.
- Next state is SHIFT if shamt!=0, else DONE.
REQ-006 In IDLE with start=0, the state and all outputs SHALL hold.
REQ-007 Each edge in SHIFT SHALL perform one step and decrement the counter.
- op=0: work <= {work[6:0],1'b0}.
- op=1: work <= {work[6:0],work[7]}.
REQ-008 In SHIFT, when the counter equals 1, the same edge SHALL perform the final step and move to DONE.
- The result SHALL be written to d_out on the edge that enters DONE.
REQ-009 On the edge that enters DONE with shamt=0, d_out SHALL be loaded with the unshifted operand.
REQ-010 Latency: done SHALL be high exactly in the cycle after edge E0+shamt (shamt=0: the cycle after E0).
- Total cycles from the start-sampling edge to done: shamt+1.
REQ-011 DONE SHALL last exactly one cycle, then return unconditionally to IDLE.
- start in DONE SHALL be ignored; back-to-back starts are accepted one cycle after done.
REQ-012 start, op, d_in and shamt SHALL be ignored in SHIFT and DONE.
- Input changes during an operation SHALL NOT affect its result.
REQ-013 busy SHALL be 1 only in SHIFT; done SHALL be 1 only in DONE; both are registered state decodes with no input-to-output combinational path.
REQ-014 d_out SHALL change only on entry to DONE and SHALL hold between operations.
REQ-015 The counter SHALL never wrap: it is loaded only in IDLE, and SHIFT exits at count 1.

Reset
REQ-016 reset=1 SHALL immediately, without a clock, force: state=IDLE, d_out=8'h00, busy=0, done=0, working register=8'h00, counter=0.
REQ-017 Reset asserted mid-operation SHALL abort it with no done pulse and d_out=8'h00.
- After reset deasserts, the first start SHALL be accepted normally.
REQ-018 After reset release, the block SHALL ignore start until the first rising edge at which reset is low.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- start, op=0, d_in=8'hB5, shamt=3 -> busy high 3 cycles, done one cycle after edge E0+3, d_out=8'hA8.
- start, op=1, d_in=8'hB5, shamt=3 -> d_out=8'hAD; same timing as above.
- start, op=0, d_in=8'h5A, shamt=0 -> busy never high; done in the cycle after E0; d_out=8'h5A.
- start, op=0, d_in=8'hFF, shamt=7; d_in and start toggled during SHIFT -> 7 busy cycles, one done pulse, d_out=8'h80.
- start, op=1, d_in=8'h81, shamt=7, then reset asserted at the 4th SHIFT cycle -> outputs 0 asynchronously, no done pulse.
  - Then start, op=1, d_in=8'h81, shamt=1 -> d_out=8'h03.
- Two operations back-to-back with start held high throughout -> second accepted on the first IDLE edge after done; each produces exactly one done pulse.
